dsi_packet_assembler: RTL

//  Builds DSI short/long packets from a command + payload stream and feeds dsi_lanes_controller.
//  - Short packet: one 32-bit word (DI, data0, data1, ECC).
//  - Long packet: header, WC payload bytes, 2-byte CRC, byte-packed little-endian into 32-bit words.
//  - Sits between the frame/command scheduler and the lane controller's iface_* port.

---
 rtl/dsi_pkg.sv | 28 ++
 rtl/dsi_ecc_gen.sv | 20 ++
 rtl/dsi_packet_assembler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dsi_pkg.sv
// Shared DSI definitions: data-type codes, packet header layout and the CRC-16 byte step.
package dsi_pkg;

    localparam logic [5:0] DT_DCS_SHORT_WR0 = 6'h05;
    localparam logic [5:0] DT_DCS_SHORT_WR1 = 6'h15;
    localparam logic [5:0] DT_NULL          = 6'h09;
    localparam logic [5:0] DT_BLANK         = 6'h19;
    localparam logic [5:0] DT_GEN_LONG_WR   = 6'h29;
    localparam logic [5:0] DT_DCS_LONG_WR   = 6'h39;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } dsi_hdr_t;

    // Reflected CCITT step (0x8408), data bit 0 shifted in first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/dsi_ecc_gen.sv
// DSI packet-header Hamming ECC: 24 header bits in, 6 parity bits out (combinational).
module dsi_ecc_gen (
    input  logic [23:0] d,
    output logic [5:0]  ecc
);

    assign ecc[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
                  ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign ecc[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
                  ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    assign ecc[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
                  ^ d[20] ^ d[21] ^ d[22];
    assign ecc[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
                  ^ d[20] ^ d[21] ^ d[23];
    assign ecc[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
                  ^ d[20] ^ d[22] ^ d[23];
    assign ecc[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
                  ^ d[21] ^ d[22] ^ d[23];

endmodule

// File: rtl/dsi_packet_assembler.sv
// Builds DSI short/long packets from command + payload streams into 32-bit words
// for the lane controller, with header ECC and trailing CRC-16.
module dsi_packet_assembler
    import dsi_pkg::*;
#(
    parameter bit CRC_ENABLE     = 1'b1,
    parameter bit UNDERRUN_CHECK = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_long,
    input  logic [1:0]  cmd_vc,
    input  logic [5:0]  cmd_dt,
    input  logic [15:0] cmd_wc,
    input  logic [31:0] pld_data,
    input  logic        pld_valid,
    output logic        pld_ready,
    output logic [31:0] iface_write_data,
    output logic [3:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    input  logic        iface_data_rqst,
    output logic        busy,
    output logic        err_underrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CRC     = 2'd3;

    logic [1:0]  state;
    dsi_hdr_t    hdr;
    logic        is_long;
    logic        tail_hi_only;
    logic [15:0] bytes_left;
    logic [15:0] crc;
    logic [15:0] crc_upd;
    logic [15:0] crc_fld;
    logic [15:0] tail_crc;
    logic [5:0]  hdr_ecc;
    logic [2:0]  k;
    logic [31:0] pld_masked;
    logic [31:0] last_data;
    logic [3:0]  last_strb;
    logic        advance;

    dsi_ecc_gen u_ecc (
        .d   ({hdr.wc, hdr.vc, hdr.dt}),
        .ecc (hdr_ecc)
    );

    assign advance   = !iface_write_rqst || iface_data_rqst;
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign pld_ready = (state == ST_PAYLOAD) && advance;
    assign busy      = (state != ST_IDLE) || iface_write_rqst;
    assign err_underrun = UNDERRUN_CHECK && (state == ST_PAYLOAD) && iface_data_rqst
                          && !iface_write_rqst && !pld_valid;
    assign tail_crc  = CRC_ENABLE ? crc : 16'h0000;

    // k = payload bytes carried by the current word; the CRC fills in right behind them.
    always_comb begin
        k          = (bytes_left > 16'd4) ? 3'd4 : bytes_left[2:0];
        crc_upd    = crc;
        pld_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < k) begin
                crc_upd               = crc16_byte(crc_upd, pld_data[8*i +: 8]);
                pld_masked[8*i +: 8]  = pld_data[8*i +: 8];
            end
        end
        crc_fld   = CRC_ENABLE ? crc_upd : 16'h0000;
        last_data = pld_masked;
        last_strb = 4'hF;
        case (k)
            3'd1: begin
                last_data = {8'h00, crc_fld, pld_masked[7:0]};
                last_strb = 4'h7;
            end
            3'd2:    last_data = {crc_fld, pld_masked[15:0]};
            3'd3:    last_data = {crc_fld[7:0], pld_masked[23:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            hdr              <= '0;
            is_long          <= 1'b0;
            tail_hi_only     <= 1'b0;
            bytes_left       <= '0;
            crc              <= CRC_INIT;
            iface_write_data <= '0;
            iface_write_strb <= '0;
            iface_write_rqst <= 1'b0;
            iface_last_word  <= 1'b0;
        end else begin
            // A consumed (or empty) slot clears unless a new word is loaded below.
            if (advance) begin
                iface_write_rqst <= 1'b0;
                iface_write_data <= '0;
                iface_write_strb <= '0;
                iface_last_word  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        hdr          <= '{vc: cmd_vc, dt: cmd_dt, wc: cmd_wc};
                        is_long      <= cmd_long;
                        bytes_left   <= cmd_wc;
                        crc          <= CRC_INIT;
                        tail_hi_only <= 1'b0;
                        state        <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (advance) begin
                        iface_write_data <= {2'b00, hdr_ecc, hdr.wc, hdr.vc, hdr.dt};
                        iface_write_strb <= 4'hF;
                        iface_write_rqst <= 1'b1;
                        iface_last_word  <= !is_long;
                        if (!is_long)
                            state <= ST_IDLE;
                        else if (hdr.wc == 16'd0)
                            state <= ST_CRC;
                        else
                            state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (advance && pld_valid) begin
                        crc              <= crc_upd;
                        iface_write_rqst <= 1'b1;
                        if (bytes_left > 16'd4) begin
                            iface_write_data <= pld_data;
                            iface_write_strb <= 4'hF;
                            bytes_left       <= bytes_left - 16'd4;
                        end else begin
                            iface_write_data <= last_data;
                            iface_write_strb <= last_strb;
                            bytes_left       <= '0;
                            if (k <= 3'd2) begin
                                iface_last_word <= 1'b1;
                                state           <= ST_IDLE;
                            end else begin
                                tail_hi_only <= (k == 3'd3);
                                state        <= ST_CRC;
                            end
                        end
                    end
                end
                default: begin
                    if (advance) begin
                        iface_write_data <= tail_hi_only ? {24'h0, tail_crc[15:8]} : {16'h0, tail_crc};
                        iface_write_strb <= tail_hi_only ? 4'h1 : 4'h3;
                        iface_write_rqst <= 1'b1;
                        iface_last_word  <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
